// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl -- main control FSM of the multicycle RV32IM core.
//
// Each instruction walks FETCH -> DECODE -> (execute states) -> FETCH. Every
// state drives the datapath controls for exactly one cycle. Outputs are Moore
// per state. The exceptions are PCWrite in BRANCH, which depends on Zero, and
// md_start.
//
// Optional feature macro: MULDIV_EN
//   defined   : an R-type op with funct7b0=1 goes EXECR -> MDWAIT -> MDWB.
//               EXECR pulses md_start and MDWAIT holds until md_done.
//   undefined : funct7b0 is ignored, md_start is tied 0, MDWAIT/MDWB unused.
//
// Ports
//   clk, rst_n              : clock; async active-low reset
//   op, funct3              : IR[6:0], IR[14:12]
//   funct7b5, funct7b0      : IR[30], IR[25]
//   Zero                    : ALU result == 0
//   md_done                 : multiply/divide result valid pulse
//   PCWrite, IRWrite,
//   MemWrite, RegWrite      : write enables (forced 0 while in reset)
//   AdrSrc                  : 0=PC, 1=Result
//   ResultSrc               : 00 ALUOut, 01 Data, 10 ALUResult, 11 MulDiv
//   ALUSrcA                 : 00 PC, 01 OldPC, 10 RD1, 11 zero
//   ALUSrcB                 : 00 RD2, 01 ImmExt, 10 constant 4
//   ALUControl              : ALU operation code
//   ImmSrc                  : 000 I, 001 S, 010 B, 011 J, 100 U
//   md_start                : one-cycle start pulse to the mul/div unit
//   IllegalInstr            : one-cycle pulse in DECODE on an unknown opcode
//   state                   : current state (debug)
module multicycle_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       funct7b0,
  input  logic       Zero,
  input  logic       md_done,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [3:0] ALUControl,
  output logic [2:0] ImmSrc,
  output logic       md_start,
  output logic       IllegalInstr,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,  DECODE   = 4'd1,  MEMADR   = 4'd2,  MEMREAD  = 4'd3,
    MEMWB    = 4'd4,  MEMWRITE = 4'd5,  EXECR    = 4'd6,  EXECI    = 4'd7,
    ALUWB    = 4'd8,  JAL      = 4'd9,  JALR     = 4'd10, JALRWB   = 4'd11,
    BRANCH   = 4'd12, UPPER    = 4'd13, MDWAIT   = 4'd14, MDWB     = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  state_t cur, nxt;

  // raw per-state controls, before reset gating
  logic pc_we, ir_we, mem_we, rf_we, md_go, illegal;

  // ---------------------------------------------------------------------
  // funct3 -> ALU op for register/immediate arithmetic. funct7b5 selects
  // sub only for R-type: in I-type that bit belongs to the immediate.
  // For shifts it selects sra in both formats.
  // ---------------------------------------------------------------------
  logic [3:0] arith_op;
  always_comb begin
    arith_op = ALU_ADD;
    case (funct3)
      3'b000:  arith_op = (cur == EXECR && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  arith_op = ALU_SLL;
      3'b010:  arith_op = ALU_SLT;
      3'b011:  arith_op = ALU_SLTU;
      3'b100:  arith_op = ALU_XOR;
      3'b101:  arith_op = funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  arith_op = ALU_OR;
      default: arith_op = ALU_AND;
    endcase
  end

  // ---------------------------------------------------------------------
  // Branch compare op and taken decision. slt/sltu return 1 when "less",
  // so Zero=0 means less-than, and Zero=1 means greater-or-equal.
  // ---------------------------------------------------------------------
  logic [3:0] br_op;
  logic       br_taken;
  always_comb begin
    br_op    = ALU_ADD;
    br_taken = 1'b0;
    case (funct3)
      3'b000:  begin br_op = ALU_SUB;  br_taken =  Zero; end
      3'b001:  begin br_op = ALU_SUB;  br_taken = ~Zero; end
      3'b100:  begin br_op = ALU_SLT;  br_taken = ~Zero; end
      3'b101:  begin br_op = ALU_SLT;  br_taken =  Zero; end
      3'b110:  begin br_op = ALU_SLTU; br_taken = ~Zero; end
      3'b111:  begin br_op = ALU_SLTU; br_taken =  Zero; end
      default: begin br_op = ALU_ADD;  br_taken = 1'b0;  end
    endcase
  end

  // M-extension hand-off condition
  logic is_md;
`ifdef MULDIV_EN
  assign is_md = (op == OP_R) && funct7b0;
`else
  assign is_md = 1'b0;
  logic unused_f7b0;
  assign unused_f7b0 = funct7b0;
`endif

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur <= FETCH;
    else        cur <= nxt;
  end

  // ---------------------------------------------------------------------
  // Next state and per-state controls
  // ---------------------------------------------------------------------
  always_comb begin
    nxt        = cur;
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    mem_we     = 1'b0;
    rf_we      = 1'b0;
    md_go      = 1'b0;
    illegal    = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = ALU_ADD;
    ImmSrc     = IMM_I;
    case (cur)
      FETCH: begin
        // read IR from mem[PC] and advance PC by 4
        ir_we     = 1'b1;
        AdrSrc    = 1'b0;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        pc_we     = 1'b1;
        nxt       = DECODE;
      end
      DECODE: begin
        // OldPC + imm lands in ALUOut as the jal / branch target
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = (op == OP_JAL) ? IMM_J : IMM_B;
        case (op)
          OP_LOAD, OP_STORE: nxt = MEMADR;
          OP_R:              nxt = EXECR;
          OP_I:              nxt = EXECI;
          OP_JAL:            nxt = JAL;
          OP_JALR:           nxt = JALR;
          OP_BR:             nxt = BRANCH;
          OP_LUI, OP_AUIPC:  nxt = UPPER;
          default: begin
            nxt     = FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ImmSrc  = op[5] ? IMM_S : IMM_I;
        nxt     = op[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        AdrSrc    = 1'b1;
        ResultSrc = 2'b00;
        nxt       = MEMWB;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        rf_we     = 1'b1;
        nxt       = FETCH;
      end
      MEMWRITE: begin
        AdrSrc    = 1'b1;
        ResultSrc = 2'b00;
        mem_we    = 1'b1;
        nxt       = FETCH;
      end
      EXECR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b00;
        ALUControl = arith_op;
        // a done pulse seen here is not for this op and is dropped:
        // MDWAIT is entered regardless of md_done
        md_go      = is_md;
        nxt        = is_md ? MDWAIT : ALUWB;
      end
      EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ImmSrc     = IMM_I;
        ALUControl = arith_op;
        nxt        = ALUWB;
      end
      ALUWB: begin
        ResultSrc = 2'b00;
        rf_we     = 1'b1;
        nxt       = FETCH;
      end
      JAL: begin
        // PC <- target held in ALUOut, then OldPC+4 into ALUOut for ALUWB
        ResultSrc = 2'b00;
        pc_we     = 1'b1;
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        nxt       = ALUWB;
      end
      JALR: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ImmSrc    = IMM_I;
        ResultSrc = 2'b10;
        pc_we     = 1'b1;
        nxt       = JALRWB;
      end
      JALRWB: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        rf_we     = 1'b1;
        nxt       = FETCH;
      end
      BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUControl = br_op;
        pc_we      = br_taken;
        nxt        = FETCH;
      end
      UPPER: begin
        // lui adds the immediate to zero, auipc adds it to OldPC
        ALUSrcA = op[5] ? 2'b11 : 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = IMM_U;
        nxt     = ALUWB;
      end
      MDWAIT: begin
        nxt = md_done ? MDWB : MDWAIT;
      end
      MDWB: begin
        ResultSrc = 2'b11;
        rf_we     = 1'b1;
        nxt       = FETCH;
      end
      default: nxt = FETCH;
    endcase
  end

  // Reset holds every write strobe low, even though FETCH would set them.
  assign PCWrite      = pc_we   & rst_n;
  assign IRWrite      = ir_we   & rst_n;
  assign MemWrite     = mem_we  & rst_n;
  assign RegWrite     = rf_we   & rst_n;
  assign md_start     = md_go   & rst_n;
  assign IllegalInstr = illegal & rst_n;
  assign state        = cur;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, funct7b0, Zero, md_done;
  logic       PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [3:0] ALUControl;
  logic [2:0] ImmSrc;
  logic       md_start, IllegalInstr;
  logic [3:0] state;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3),
    .funct7b5(funct7b5), .funct7b0(funct7b0), .Zero(Zero), .md_done(md_done),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .ImmSrc(ImmSrc), .md_start(md_start), .IllegalInstr(IllegalInstr),
    .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // one instruction: inputs plus expected trace/controls
  typedef struct {
    string      name;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7b5, f7b0, zero;
    int         len;
    logic [23:0] seq;   // state of cycle i in nibble i
    logic [2:0] imm1;   // ImmSrc in DECODE
    logic [1:0] sa2, sb2, rs2;
    logic [3:0] alu2;
    logic [2:0] imm2;   // controls of the third state (if any)
    int         nreg, nmem, npc, nill;
  } vec_t;

  vec_t vecs[$];
  logic [3:0] exp_q[$];

  // per-cycle log of the last instruction, for hand-written checks
  logic [3:0] st_log[16];
  logic       rw_log[16], ir_log[16], ad_log[16];
  logic [1:0] sa_log[16], sb_log[16], rs_log[16];

  function automatic vec_t mk(input string nm, input logic [6:0] o,
      input logic [2:0] f3, input logic b5, input logic b0, input logic z,
      input int len, input logic [23:0] seq, input logic [2:0] imm1,
      input logic [1:0] sa, input logic [1:0] sb, input logic [1:0] rs,
      input logic [3:0] alu, input logic [2:0] imm2,
      input int nreg, input int nmem, input int npc, input int nill);
    vec_t v;
    v.name = nm; v.op = o; v.f3 = f3; v.f7b5 = b5; v.f7b0 = b0; v.zero = z;
    v.len = len; v.seq = seq; v.imm1 = imm1; v.sa2 = sa; v.sb2 = sb;
    v.rs2 = rs; v.alu2 = alu; v.imm2 = imm2; v.nreg = nreg; v.nmem = nmem;
    v.npc = npc; v.nill = nill;
    return v;
  endfunction

  // entered just after a posedge with the DUT in FETCH; leaves the same way
  task automatic run(input vec_t v);
    int nreg, nmem, npc, nill, nmd;
    logic [3:0] e;
    nreg = 0; nmem = 0; npc = 0; nill = 0; nmd = 0;
    op = v.op; funct3 = v.f3; funct7b5 = v.f7b5; funct7b0 = v.f7b0;
    Zero = v.zero;
    for (int i = 0; i < v.len; i++) exp_q.push_back(v.seq[4*i +: 4]);
    for (int i = 0; i < v.len; i++) begin
      @(negedge clk);
      st_log[i] = state; rw_log[i] = RegWrite; ir_log[i] = IRWrite;
      ad_log[i] = AdrSrc; sa_log[i] = ALUSrcA; sb_log[i] = ALUSrcB;
      rs_log[i] = ResultSrc;
      if (exp_q.size() == 0) chk({v.name, " queue underrun"}, 1, 0);
      else begin
        e = exp_q.pop_front();
        chk($sformatf("%s state[%0d]", v.name, i), int'(state), int'(e));
      end
      if (i == 1) chk({v.name, " ImmSrc decode"}, int'(ImmSrc), int'(v.imm1));
      if (i == 2) begin
        chk({v.name, " ALUSrcA"},    int'(ALUSrcA),    int'(v.sa2));
        chk({v.name, " ALUSrcB"},    int'(ALUSrcB),    int'(v.sb2));
        chk({v.name, " ResultSrc"},  int'(ResultSrc),  int'(v.rs2));
        chk({v.name, " ALUControl"}, int'(ALUControl), int'(v.alu2));
        chk({v.name, " ImmSrc"},     int'(ImmSrc),     int'(v.imm2));
      end
      nreg += int'(RegWrite); nmem += int'(MemWrite); npc += int'(PCWrite);
      nill += int'(IllegalInstr); nmd += int'(md_start);
      @(posedge clk); #1;
    end
    chk({v.name, " RegWrite cycles"}, nreg, v.nreg);
    chk({v.name, " MemWrite cycles"}, nmem, v.nmem);
    chk({v.name, " PCWrite cycles"},  npc,  v.npc);
    chk({v.name, " Illegal pulses"},  nill, v.nill);
    chk({v.name, " md_start pulses"}, nmd,  0);
    chk({v.name, " back to FETCH"},   int'(state), 0);
  endtask

  initial begin
    //            name      op        f3     b5 b0 z  len seq       imm1    sa    sb    rs    alu      imm2   reg mem pc ill
    vecs.push_back(mk("lw",    7'h03, 3'b010, 0, 0, 0, 5, 24'h43210, 3'b010, 2'd2, 2'd1, 2'd0, 4'h0, 3'b000, 1, 0, 1, 0));
    vecs.push_back(mk("sw",    7'h23, 3'b010, 0, 0, 0, 4, 24'h05210, 3'b010, 2'd2, 2'd1, 2'd0, 4'h0, 3'b001, 0, 1, 1, 0));
    vecs.push_back(mk("add",   7'h33, 3'b000, 0, 0, 0, 4, 24'h08610, 3'b010, 2'd2, 2'd0, 2'd0, 4'h0, 3'b000, 1, 0, 1, 0));
    vecs.push_back(mk("sub",   7'h33, 3'b000, 1, 0, 0, 4, 24'h08610, 3'b010, 2'd2, 2'd0, 2'd0, 4'h1, 3'b000, 1, 0, 1, 0));
    vecs.push_back(mk("sll",   7'h33, 3'b001, 0, 0, 0, 4, 24'h08610, 3'b010, 2'd2, 2'd0, 2'd0, 4'h7, 3'b000, 1, 0, 1, 0));
    vecs.push_back(mk("slt",   7'h33, 3'b010, 0, 0, 0, 4, 24'h08610, 3'b010, 2'd2, 2'd0, 2'd0, 4'h5, 3'b000, 1, 0, 1, 0));
    vecs.push_back(mk("sltu",  7'h33, 3'b011, 0, 0, 0, 4, 24'h08610, 3'b010, 2'd2, 2'd0, 2'd0, 4'h6, 3'b000, 1, 0, 1, 0));
    vecs.push_back(mk("xor",   7'h33, 3'b100, 0, 0, 0, 4, 24'h08610, 3'b010, 2'd2, 2'd0, 2'd0, 4'h4, 3'b000, 1, 0, 1, 0));
    vecs.push_back(mk("srl",   7'h33, 3'b101, 0, 0, 0, 4, 24'h08610, 3'b010, 2'd2, 2'd0, 2'd0, 4'h8, 3'b000, 1, 0, 1, 0));
    vecs.push_back(mk("sra",   7'h33, 3'b101, 1, 0, 0, 4, 24'h08610, 3'b010, 2'd2, 2'd0, 2'd0, 4'h9, 3'b000, 1, 0, 1, 0));
    vecs.push_back(mk("or",    7'h33, 3'b110, 0, 0, 0, 4, 24'h08610, 3'b010, 2'd2, 2'd0, 2'd0, 4'h3, 3'b000, 1, 0, 1, 0));
    vecs.push_back(mk("and",   7'h33, 3'b111, 0, 0, 0, 4, 24'h08610, 3'b010, 2'd2, 2'd0, 2'd0, 4'h2, 3'b000, 1, 0, 1, 0));
    vecs.push_back(mk("addi",  7'h13, 3'b000, 1, 0, 0, 4, 24'h08710, 3'b010, 2'd2, 2'd1, 2'd0, 4'h0, 3'b000, 1, 0, 1, 0));
    vecs.push_back(mk("srai",  7'h13, 3'b101, 1, 0, 0, 4, 24'h08710, 3'b010, 2'd2, 2'd1, 2'd0, 4'h9, 3'b000, 1, 0, 1, 0));
    vecs.push_back(mk("andi",  7'h13, 3'b111, 0, 0, 0, 4, 24'h08710, 3'b010, 2'd2, 2'd1, 2'd0, 4'h2, 3'b000, 1, 0, 1, 0));
    vecs.push_back(mk("jal",   7'h6F, 3'b000, 0, 0, 0, 4, 24'h08910, 3'b011, 2'd1, 2'd2, 2'd0, 4'h0, 3'b000, 1, 0, 2, 0));
    vecs.push_back(mk("beq1",  7'h63, 3'b000, 0, 0, 1, 3, 24'h00C10, 3'b010, 2'd2, 2'd0, 2'd0, 4'h1, 3'b000, 0, 0, 2, 0));
    vecs.push_back(mk("bne1",  7'h63, 3'b001, 0, 0, 1, 3, 24'h00C10, 3'b010, 2'd2, 2'd0, 2'd0, 4'h1, 3'b000, 0, 0, 1, 0));
    vecs.push_back(mk("bne0",  7'h63, 3'b001, 0, 0, 0, 3, 24'h00C10, 3'b010, 2'd2, 2'd0, 2'd0, 4'h1, 3'b000, 0, 0, 2, 0));
    vecs.push_back(mk("blt0",  7'h63, 3'b100, 0, 0, 0, 3, 24'h00C10, 3'b010, 2'd2, 2'd0, 2'd0, 4'h5, 3'b000, 0, 0, 2, 0));
    vecs.push_back(mk("bge0",  7'h63, 3'b101, 0, 0, 0, 3, 24'h00C10, 3'b010, 2'd2, 2'd0, 2'd0, 4'h5, 3'b000, 0, 0, 1, 0));
    vecs.push_back(mk("bltu1", 7'h63, 3'b110, 0, 0, 1, 3, 24'h00C10, 3'b010, 2'd2, 2'd0, 2'd0, 4'h6, 3'b000, 0, 0, 1, 0));
    vecs.push_back(mk("bgeu1", 7'h63, 3'b111, 0, 0, 1, 3, 24'h00C10, 3'b010, 2'd2, 2'd0, 2'd0, 4'h6, 3'b000, 0, 0, 2, 0));
    vecs.push_back(mk("br010", 7'h63, 3'b010, 0, 0, 1, 3, 24'h00C10, 3'b010, 2'd2, 2'd0, 2'd0, 4'h0, 3'b000, 0, 0, 1, 0));
    vecs.push_back(mk("lui",   7'h37, 3'b000, 0, 0, 0, 4, 24'h08D10, 3'b010, 2'd3, 2'd1, 2'd0, 4'h0, 3'b100, 1, 0, 1, 0));
    vecs.push_back(mk("auipc", 7'h17, 3'b000, 0, 0, 0, 4, 24'h08D10, 3'b010, 2'd1, 2'd1, 2'd0, 4'h0, 3'b100, 1, 0, 1, 0));
    vecs.push_back(mk("ill7f", 7'h7F, 3'b000, 0, 0, 0, 2, 24'h00010, 3'b010, 2'd0, 2'd0, 2'd0, 4'h0, 3'b000, 0, 0, 1, 1));
    vecs.push_back(mk("ill00", 7'h00, 3'b000, 0, 0, 0, 2, 24'h00010, 3'b010, 2'd0, 2'd0, 2'd0, 4'h0, 3'b000, 0, 0, 1, 1));
`ifndef MULDIV_EN
    // without the M extension a mul runs as a plain add
    vecs.push_back(mk("mul_as_add", 7'h33, 3'b000, 0, 1, 0, 4, 24'h08610, 3'b010, 2'd2, 2'd0, 2'd0, 4'h0, 3'b000, 1, 0, 1, 0));
`endif

    // ---- reset state ----
    rst_n = 1'b0; op = 7'h03; funct3 = 3'b0; funct7b5 = 1'b0; funct7b0 = 1'b0;
    Zero = 1'b0; md_done = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset state",    int'(state),    0);
    chk("reset PCWrite",  int'(PCWrite),  0);
    chk("reset IRWrite",  int'(IRWrite),  0);
    chk("reset RegWrite", int'(RegWrite), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // ---- table ----
    foreach (vecs[k]) begin
      run(vecs[k]);
      if (vecs[k].name == "lw") begin
        chk("fetch IRWrite",   int'(ir_log[0]), 1);
        chk("fetch AdrSrc",    int'(ad_log[0]), 0);
        chk("fetch ALUSrcA",   int'(sa_log[0]), 0);
        chk("fetch ALUSrcB",   int'(sb_log[0]), 2);
        chk("fetch ResultSrc", int'(rs_log[0]), 2);
        chk("memread AdrSrc",  int'(ad_log[3]), 1);
        chk("memwb ResultSrc", int'(rs_log[4]), 1);
        chk("memwb RegWrite",  int'(rw_log[4]), 1);
        chk("memread RegWrite", int'(rw_log[3]), 0);
      end
    end

    // ---- jalr detail ----
    run(mk("jalr", 7'h67, 3'b000, 0, 0, 0, 4, 24'h0BA10, 3'b010, 2'd2, 2'd1, 2'd2, 4'h0, 3'b000, 1, 0, 2, 0));
    chk("jalrwb RegWrite",  int'(rw_log[3]), 1);
    chk("jalrwb ALUSrcA",   int'(sa_log[3]), 1);
    chk("jalrwb ALUSrcB",   int'(sb_log[3]), 2);
    chk("jalrwb ResultSrc", int'(rs_log[3]), 2);

    // ---- reset in the middle of a lw (in MEMREAD) ----
    op = 7'h03; funct3 = 3'b010;
    repeat (3) begin @(posedge clk); #1; end
    chk("pre-reset in MEMREAD", int'(state), 3);
    rst_n = 1'b0; #1;
    chk("mid reset state", int'(state), 0);
    @(negedge clk);
    chk("mid reset PCWrite",  int'(PCWrite),  0);
    chk("mid reset IRWrite",  int'(IRWrite),  0);
    chk("mid reset RegWrite", int'(RegWrite), 0);
    chk("mid reset state held", int'(state), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run(vecs[2]);   // add after release

`ifdef MULDIV_EN
    // ---- mul with done 5 cycles after start; done during start ignored ----
    begin
      int nrw;
      nrw = 0;
      op = 7'h33; funct3 = 3'b000; funct7b5 = 1'b0; funct7b0 = 1'b1;
      @(negedge clk); chk("mul fetch", int'(state), 0);
      @(posedge clk); #1;
      @(negedge clk); chk("mul decode", int'(state), 1);
      chk("mul decode md_start", int'(md_start), 0);
      @(posedge clk); #1;
      md_done = 1'b1;
      @(negedge clk); chk("mul execr", int'(state), 6);
      chk("mul md_start", int'(md_start), 1);
      @(posedge clk); #1;
      md_done = 1'b0;
      for (int c = 1; c <= 5; c++) begin
        if (c == 5) md_done = 1'b1;
        @(negedge clk);
        chk($sformatf("mdwait state c%0d", c), int'(state), 14);
        chk($sformatf("mdwait md_start c%0d", c), int'(md_start), 0);
        nrw += int'(RegWrite) + int'(PCWrite) + int'(MemWrite) + int'(IRWrite);
        @(posedge clk); #1;
        md_done = 1'b0;
      end
      chk("mdwait enables", nrw, 0);
      @(negedge clk); chk("mdwb state", int'(state), 15);
      chk("mdwb RegWrite", int'(RegWrite), 1);
      chk("mdwb ResultSrc", int'(ResultSrc), 3);
      @(posedge clk); #1;
      chk("mul back to FETCH", int'(state), 0);

      // reset while waiting
      repeat (3) begin @(posedge clk); #1; end
      chk("pre-reset MDWAIT", int'(state), 14);
      rst_n = 1'b0; #1;
      chk("mdwait reset state", int'(state), 0);
      chk("mdwait reset RegWrite", int'(RegWrite), 0);
      chk("mdwait reset md_start", int'(md_start), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      funct7b0 = 1'b0;
      run(vecs[2]);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
